// File: rtl/inst_loader_encoder_pkg.sv
// Shared instruction-format constants, record kinds and loader state encodings.
// The opcode and field ranges match the ones the instruction decoder uses, so
// words built here decode back to the intended control path.
package inst_loader_encoder_pkg;

   // Primary opcodes
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_J    = 6'b000010;

   // R-type function code for add
   localparam logic [5:0] R_ADD_FUNCT = 6'b100000;

   // Instruction field bit ranges
   localparam int I_OP_HI     = 31;
   localparam int I_OP_LO     = 26;
   localparam int I_RS_HI     = 25;
   localparam int I_RS_LO     = 21;
   localparam int I_RT_HI     = 20;
   localparam int I_RT_LO     = 16;
   localparam int I_RD_HI     = 15;
   localparam int I_RD_LO     = 11;
   localparam int I_SHAMT_HI  = 10;
   localparam int I_SHAMT_LO  = 6;
   localparam int I_FUNCT_HI  = 5;
   localparam int I_FUNCT_LO  = 0;
   localparam int I_IMM_HI    = 15;
   localparam int I_IMM_LO    = 0;
   localparam int I_TARGET_HI = 25;
   localparam int I_TARGET_LO = 0;

   // Symbolic record kinds; encodings 5..7 are illegal
   typedef enum logic [2:0] {
      KIND_ADD  = 3'd0,
      KIND_ADDI = 3'd1,
      KIND_LW   = 3'd2,
      KIND_SW   = 3'd3,
      KIND_J    = 3'd4
   } kind_e;

   // Loader session states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Builds an I-type word: opcode, base/source register, target register, immediate
   function automatic logic [31:0] pack_itype(input logic [5:0]  op,
                                              input logic [4:0]  rs,
                                              input logic [4:0]  rt,
                                              input logic [15:0] imm);
      logic [31:0] w;
      w = '0;
      w[I_OP_HI:I_OP_LO]   = op;
      w[I_RS_HI:I_RS_LO]   = rs;
      w[I_RT_HI:I_RT_LO]   = rt;
      w[I_IMM_HI:I_IMM_LO] = imm;
      return w;
   endfunction

endpackage

// File: rtl/inst_field_pack.sv
// Combinational encoder from a symbolic record (kind plus fields) to a 32-bit
// instruction word. Fields a kind does not use are dropped and emitted as 0.
module inst_field_pack
   import inst_loader_encoder_pkg::*;
(
   input  logic [2:0]  kind,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        illegal
);

   // Select the format for the kind and place each field at its bit range
   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (kind)
         KIND_ADD: begin
            word[I_OP_HI:I_OP_LO]       = OP_R;
            word[I_RS_HI:I_RS_LO]       = rs;
            word[I_RT_HI:I_RT_LO]       = rt;
            word[I_RD_HI:I_RD_LO]       = rd;
            word[I_SHAMT_HI:I_SHAMT_LO] = 5'd0;
            word[I_FUNCT_HI:I_FUNCT_LO] = R_ADD_FUNCT;
         end
         KIND_ADDI: word = pack_itype(OP_ADDI, rs, rt, imm);
         KIND_LW:   word = pack_itype(OP_LW, rs, rt, imm);
         KIND_SW:   word = pack_itype(OP_SW, rs, rt, imm);
         KIND_J: begin
            word[I_OP_HI:I_OP_LO]         = OP_J;
            word[I_TARGET_HI:I_TARGET_LO] = target;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/inst_loader_encoder.sv
// Program loader: accepts symbolic instruction records, encodes them through a
// one-entry stage register and writes the words to consecutive imem addresses
// starting at BASE_ADDR. Overflow and illegal kinds raise a sticky err flag.
module inst_loader_encoder
   import inst_loader_encoder_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_kind,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   input  logic              in_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   // Words that fit between BASE_ADDR and the top of imem
   localparam int              CAP_INT = (1 << ADDR_W) - BASE_ADDR;
   localparam logic [ADDR_W:0] CAP     = CAP_INT[ADDR_W:0];
   localparam logic [ADDR_W-1:0] BASE  = BASE_ADDR[ADDR_W-1:0];

   state_e              state;
   state_e              state_nxt;
   logic [ADDR_W-1:0]   addr;
   logic [ADDR_W:0]     occupancy;
   logic                full;
   logic                err_set;
   logic                session_start;

   logic [31:0]         pack_word_p0;
   logic                pack_illegal_p0;
   logic                accept_p0;
   logic                vld_p0;

   logic [31:0]         stage_word_p1;
   logic                stage_vld_p1;

   inst_field_pack u_pack (
      .kind    (in_kind),
      .rs      (in_rs),
      .rt      (in_rt),
      .rd      (in_rd),
      .imm     (in_imm),
      .target  (in_target),
      .word    (pack_word_p0),
      .illegal (pack_illegal_p0)
   );

   // Words already written plus the one waiting in the stage; at CAP nothing more fits
   always_comb begin
      occupancy = count + {{ADDR_W{1'b0}}, stage_vld_p1};
      full      = (occupancy == CAP);
   end

   // Next-state logic, record handshake and error detection
   always_comb begin
      state_nxt     = state;
      in_ready      = 1'b0;
      err_set       = 1'b0;
      session_start = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt     = ST_LOAD;
               session_start = 1'b1;
            end
         end
         ST_LOAD: begin
            in_ready = !full;
            if (full) begin
               // Ran out of room before the last record arrived
               err_set   = 1'b1;
               state_nxt = ST_FLUSH;
            end else if (in_valid) begin
               if (pack_illegal_p0) err_set = 1'b1;
               if (in_last) state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      accept_p0 = in_valid && in_ready;
      vld_p0    = accept_p0 && !pack_illegal_p0;
   end

   // Session state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Stage p0 -> p1: stage occupancy, write pointer, word count and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_vld_p1 <= 1'b0;
         addr         <= BASE;
         count        <= '0;
         err          <= 1'b0;
      end else begin
         stage_vld_p1 <= vld_p0;
         if (session_start) begin
            addr  <= BASE;
            count <= '0;
            err   <= 1'b0;
         end else begin
            if (stage_vld_p1) begin
               count <= count + 1'b1;
               // Hold at the top address; full blocks any write beyond it
               if (addr != {ADDR_W{1'b1}}) addr <= addr + 1'b1;
            end
            if (err_set) err <= 1'b1;
         end
      end
   end

   // Stage p0 -> p1 data: encoded word captured on a legal accept
   always_ff @(posedge clk) begin
      if (vld_p0) stage_word_p1 <= pack_word_p0;
   end

   // Stage p1: the pending word is written during the cycle after its accept
   always_comb begin
      imem_we    = stage_vld_p1;
      imem_addr  = stage_vld_p1 ? addr : '0;
      imem_wdata = stage_vld_p1 ? stage_word_p1 : 32'h0;
      busy       = (state == ST_LOAD) || (state == ST_FLUSH);
      done       = (state == ST_DONE);
   end

endmodule

// File: tb/tb_inst_loader_encoder.sv
// Directed bench for inst_loader_encoder: a default instance (ADDR_W=8,
// BASE_ADDR=0) and a small one (ADDR_W=2, BASE_ADDR=1) for overflow.
module tb_inst_loader_encoder;

   logic        clk;
   logic        rst_n;
   logic        start, s_start;
   logic        in_valid, s_in_valid;
   logic [2:0]  in_kind;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        in_last;

   logic        in_ready, imem_we, busy, done, err;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [8:0]  count;

   logic        s_in_ready, s_imem_we, s_busy, s_done, s_err;
   logic [1:0]  s_imem_addr;
   logic [31:0] s_imem_wdata;
   logic [2:0]  s_count;

   int errors = 0;
   int checks = 0;
   logic [31:0] cap [5];

   inst_loader_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt),
      .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .busy(busy), .done(done), .err(err), .count(count)
   );

   inst_loader_encoder #(.ADDR_W(2), .BASE_ADDR(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid),
      .in_ready(s_in_ready), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt),
      .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
      .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
      .busy(s_busy), .done(s_done), .err(s_err), .count(s_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic rec(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic last);
      in_kind   = k;
      in_rs     = rs;
      in_rt     = rt;
      in_rd     = rd;
      in_imm    = imm;
      in_target = tgt;
      in_last   = last;
   endtask

   // Reference decoder control vector {REG_WR, ALU_SRC, RAM_WR, JMP}
   function automatic logic [3:0] cpath(input logic [31:0] w);
      case (w[31:26])
         6'b000000: return (w[5:0] == 6'b100000) ? 4'b1000 : 4'b0000;
         6'b001000: return 4'b1100;
         6'b100011: return 4'b1100;
         6'b101011: return 4'b0110;
         6'b000010: return 4'b0001;
         default:   return 4'b0000;
      endcase
   endfunction

   initial begin
      rst_n = 1'b0; start = 1'b0; s_start = 1'b0;
      in_valid = 1'b0; s_in_valid = 1'b0;
      rec(3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
      tick(); tick();

      // Reset state
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_we",       32'(imem_we), 32'd0);
      chk("rst_addr",     32'(imem_addr), 32'd0);
      chk("rst_wdata",    imem_wdata, 32'h0);
      chk("rst_busy",     32'(busy), 32'd0);
      chk("rst_done",     32'(done), 32'd0);
      chk("rst_err",      32'(err), 32'd0);
      chk("rst_count",    32'(count), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_in_ready", 32'(in_ready), 32'd0);

      // Single add record with last
      start = 1'b1; tick(); start = 1'b0;
      chk("t1_busy",  32'(busy), 32'd1);
      chk("t1_ready", 32'(in_ready), 32'd1);
      rec(3'd0, 5'd1, 5'd2, 5'd3, 16'hffff, 26'h3ffffff, 1'b1);
      in_valid = 1'b1; tick(); in_valid = 1'b0;
      chk("t1_we",    32'(imem_we), 32'd1);
      chk("t1_addr",  32'(imem_addr), 32'h00);
      chk("t1_wdata", imem_wdata, 32'h00221820);
      cap[0] = imem_wdata;
      chk("t1_ready_flush", 32'(in_ready), 32'd0);
      tick();
      chk("t1_done",  32'(done), 32'd1);
      chk("t1_we_done", 32'(imem_we), 32'd0);
      chk("t1_count", 32'(count), 32'd1);
      chk("t1_err",   32'(err), 32'd0);
      tick();
      chk("t1_done_pulse", 32'(done), 32'd0);
      chk("t1_count_hold", 32'(count), 32'd1);

      // Back-to-back addi, lw, sw, j
      start = 1'b1; tick(); start = 1'b0;
      chk("t2_count_clr", 32'(count), 32'd0);
      in_valid = 1'b1;
      rec(3'd1, 5'd0, 5'd8, 5'd0, 16'd5, 26'h0, 1'b0); tick();
      chk("t2_we0", 32'(imem_we), 32'd1);
      chk("t2_a0",  32'(imem_addr), 32'd0);
      chk("t2_w0",  imem_wdata, 32'h20080005);
      cap[1] = imem_wdata;
      chk("t2_ready", 32'(in_ready), 32'd1);
      rec(3'd2, 5'd29, 5'd9, 5'd0, 16'd4, 26'h0, 1'b0); tick();
      chk("t2_we1", 32'(imem_we), 32'd1);
      chk("t2_a1",  32'(imem_addr), 32'd1);
      chk("t2_w1",  imem_wdata, 32'h8FA90004);
      cap[2] = imem_wdata;
      rec(3'd3, 5'd29, 5'd9, 5'd0, 16'd8, 26'h0, 1'b0); tick();
      chk("t2_we2", 32'(imem_we), 32'd1);
      chk("t2_a2",  32'(imem_addr), 32'd2);
      chk("t2_w2",  imem_wdata, 32'hAFA90008);
      cap[3] = imem_wdata;
      rec(3'd4, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1); tick();
      in_valid = 1'b0;
      chk("t2_we3", 32'(imem_we), 32'd1);
      chk("t2_a3",  32'(imem_addr), 32'd3);
      chk("t2_w3",  imem_wdata, 32'h08000010);
      cap[4] = imem_wdata;
      tick();
      chk("t2_done",  32'(done), 32'd1);
      chk("t2_count", 32'(count), 32'd4);
      tick();

      // Decoded control path of each emitted word
      chk("cp_add",  32'(cpath(cap[0])), 32'b1000);
      chk("cp_addi", 32'(cpath(cap[1])), 32'b1100);
      chk("cp_lw",   32'(cpath(cap[2])), 32'b1100);
      chk("cp_sw",   32'(cpath(cap[3])), 32'b0110);
      chk("cp_j",    32'(cpath(cap[4])), 32'b0001);

      // Illegal kind between two adds
      start = 1'b1; tick(); start = 1'b0;
      in_valid = 1'b1;
      rec(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0); tick();
      chk("t3_w0", imem_wdata, 32'h00221820);
      chk("t3_a0", 32'(imem_addr), 32'd0);
      rec(3'd6, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h0, 1'b0); tick();
      chk("t3_we_ill", 32'(imem_we), 32'd0);
      chk("t3_err",    32'(err), 32'd1);
      rec(3'd0, 5'd5, 5'd6, 5'd4, 16'h0, 26'h0, 1'b1); tick();
      in_valid = 1'b0;
      chk("t3_we1", 32'(imem_we), 32'd1);
      chk("t3_a1",  32'(imem_addr), 32'd1);
      chk("t3_w1",  imem_wdata, 32'h00A62020);
      tick();
      chk("t3_done",  32'(done), 32'd1);
      chk("t3_count", 32'(count), 32'd2);
      chk("t3_err_hold", 32'(err), 32'd1);
      tick();

      // Overflow on the small instance: 3 slots at addrs 1..3, no last
      s_start = 1'b1; tick(); s_start = 1'b0;
      s_in_valid = 1'b1;
      rec(3'd4, 5'd0, 5'd0, 5'd0, 16'h0, 26'h1, 1'b0); tick();
      chk("t4_a0", 32'(s_imem_addr), 32'd1);
      chk("t4_w0", s_imem_wdata, 32'h08000001);
      rec(3'd4, 5'd0, 5'd0, 5'd0, 16'h0, 26'h2, 1'b0); tick();
      chk("t4_a1", 32'(s_imem_addr), 32'd2);
      chk("t4_w1", s_imem_wdata, 32'h08000002);
      chk("t4_ready1", 32'(s_in_ready), 32'd1);
      rec(3'd4, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3, 1'b0); tick();
      chk("t4_a2", 32'(s_imem_addr), 32'd3);
      chk("t4_w2", s_imem_wdata, 32'h08000003);
      chk("t4_ready_full", 32'(s_in_ready), 32'd0);
      rec(3'd4, 5'd0, 5'd0, 5'd0, 16'h0, 26'h4, 1'b0); tick();
      chk("t4_we_none", 32'(s_imem_we), 32'd0);
      chk("t4_err",     32'(s_err), 32'd1);
      chk("t4_busy",    32'(s_busy), 32'd1);
      rec(3'd4, 5'd0, 5'd0, 5'd0, 16'h0, 26'h5, 1'b0); tick();
      s_in_valid = 1'b0;
      chk("t4_done",  32'(s_done), 32'd1);
      chk("t4_count", 32'(s_count), 32'd3);
      chk("t4_we_done", 32'(s_imem_we), 32'd0);
      tick();

      // Asynchronous reset with a stage word pending
      start = 1'b1; tick(); start = 1'b0;
      chk("t5_err_clr", 32'(err), 32'd0);
      in_valid = 1'b1;
      rec(3'd1, 5'd2, 5'd3, 5'd0, 16'h00ff, 26'h0, 1'b0); tick();
      in_valid = 1'b0;
      chk("t5_we_pend", 32'(imem_we), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_we",    32'(imem_we), 32'd0);
      chk("t5_addr",  32'(imem_addr), 32'd0);
      chk("t5_wdata", imem_wdata, 32'h0);
      chk("t5_busy",  32'(busy), 32'd0);
      chk("t5_count", 32'(count), 32'd0);
      chk("t5_ready", 32'(in_ready), 32'd0);
      tick();
      chk("t5_we_hold", 32'(imem_we), 32'd0);
      rst_n = 1'b1;
      tick(); tick();
      chk("t5_idle_ready", 32'(in_ready), 32'd0);
      chk("t5_idle_busy",  32'(busy), 32'd0);
      chk("t5_idle_we",    32'(imem_we), 32'd0);
      start = 1'b1; tick(); start = 1'b0;
      chk("t5_restart_ready", 32'(in_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
